uart_runner: RTL and testbench

UART_RUNNER -- requirements
Module: uart_runner

---
 rtl/uart_runner.sv | 236 +++++++++++++++++++++++
 tb/tb_uart_runner.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_runner.sv
// uart_runner: UART packet engine that echoes (opcode 0xEC) or sums (opcode 0x10) packet payloads back on TX.
// Ports: clk_i clock; rst_ni async active-low reset; rx_i UART receive (idle high);
//        tx_o UART transmit (idle high); busy_o high while a packet, FIFO or transmitter is active.
// Define UART_RUNNER_ADD32_EN to build the 32-bit accumulator for opcode 0x10; otherwise 0x10 is discarded.
module uart_runner #(
    parameter int CLK_FREQ_HZ = 12000000,
    parameter int BAUD_RATE   = 115200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rx_i,
    output logic tx_o,
    output logic busy_o
);
    localparam int CPB = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CW  = $clog2(CPB + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] C_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] C_HALF = CW'(CPB / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_t;
    typedef enum logic [2:0] {P_OPCODE, P_RSVD, P_LEN_LO, P_LEN_HI, P_PAYLOAD} p_t;
    typedef enum logic {TX_IDLE, TX_BUSY} tx_t;

    rx_t           r_rx_st, w_rx_nx;
    logic          r_rx_meta, r_rx_sync, r_rx_prev;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_data;
    logic          w_rx_tick, w_rx_valid;

    p_t            r_p_st, w_p_nx;
    logic [7:0]    r_op, r_len_lo;
    logic [15:0]   r_remain, w_len;
    logic          w_pkt_done, w_echo_push;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_cnt;
    logic          w_push, w_wr, w_pop, w_full, w_empty;
    logic [7:0]    w_push_data, w_res_byte;
    logic          w_res_push, w_res_busy;

    tx_t           r_tx_st, w_tx_nx;
    logic [9:0]    r_tx_sh;
    logic [CW-1:0] r_tx_cnt;
    logic [3:0]    r_tx_bit;
    logic          w_tx_end;

    // Start bit is re-checked half a bit in; every later sample lands one full bit later (mid-bit).
    assign w_rx_tick = r_rx_cnt == ((r_rx_st == RX_START) ? C_HALF : C_LAST);

    always_comb begin
        w_rx_nx    = r_rx_st;
        w_rx_valid = 1'b0;
        case (r_rx_st)
            RX_IDLE:  if (r_rx_prev && !r_rx_sync) w_rx_nx = RX_START;
            RX_START: if (w_rx_tick) w_rx_nx = r_rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_nx = RX_STOP;
            RX_STOP:  if (w_rx_tick) begin
                w_rx_nx    = RX_IDLE;
                w_rx_valid = r_rx_sync;
            end
            default:  w_rx_nx = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
            r_rx_st   <= RX_IDLE;
            r_rx_cnt  <= '0;
            r_rx_bit  <= '0;
            r_rx_data <= '0;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
            r_rx_st   <= w_rx_nx;
            r_rx_cnt  <= (r_rx_st == RX_IDLE || w_rx_tick) ? '0 : r_rx_cnt + 1'b1;
            if (r_rx_st == RX_DATA && w_rx_tick) begin
                r_rx_data <= {r_rx_sync, r_rx_data[7:1]};
                r_rx_bit  <= r_rx_bit + 1'b1;
            end
        end
    end

    assign w_len       = {r_rx_data, r_len_lo};
    assign w_echo_push = w_rx_valid && r_p_st == P_PAYLOAD && r_op == 8'hEC;

    always_comb begin
        w_p_nx     = r_p_st;
        w_pkt_done = 1'b0;
        if (w_rx_valid) begin
            case (r_p_st)
                P_OPCODE:  w_p_nx = P_RSVD;
                P_RSVD:    w_p_nx = P_LEN_LO;
                P_LEN_LO:  w_p_nx = P_LEN_HI;
                P_LEN_HI:  begin
                    w_pkt_done = w_len <= 16'd4;
                    w_p_nx     = w_pkt_done ? P_OPCODE : P_PAYLOAD;
                end
                P_PAYLOAD: begin
                    w_pkt_done = r_remain == 16'd1;
                    w_p_nx     = w_pkt_done ? P_OPCODE : P_PAYLOAD;
                end
                default:   w_p_nx = P_OPCODE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_p_st   <= P_OPCODE;
            r_op     <= '0;
            r_len_lo <= '0;
            r_remain <= '0;
        end else begin
            r_p_st <= w_p_nx;
            if (w_rx_valid && r_p_st == P_OPCODE) r_op <= r_rx_data;
            if (w_rx_valid && r_p_st == P_LEN_LO) r_len_lo <= r_rx_data;
            if (w_rx_valid && r_p_st == P_LEN_HI) r_remain <= w_len - 16'd4;
            if (w_rx_valid && r_p_st == P_PAYLOAD) r_remain <= r_remain - 16'd1;
        end
    end

`ifdef UART_RUNNER_ADD32_EN
    logic [31:0] r_acc, r_res, w_acc_nx;
    logic [23:0] r_word;
    logic [1:0]  r_bcnt;
    logic [2:0]  r_res_cnt;
    logic        w_add;

    assign w_add = w_rx_valid && r_p_st == P_PAYLOAD && r_op == 8'h10;
    // A word joins the sum on its fourth byte, so a trailing partial word never does.
    assign w_acc_nx = (w_add && r_bcnt == 2'd3) ? r_acc + {r_rx_data, r_word} : r_acc;
    // The first result byte waits for an empty FIFO; the other three follow on consecutive cycles.
    assign w_res_push = r_res_cnt != 3'd0 && (r_res_cnt != 3'd4 || w_empty);
    assign w_res_byte = r_res[7:0];
    assign w_res_busy = r_res_cnt != 3'd0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_acc     <= '0;
            r_res     <= '0;
            r_word    <= '0;
            r_bcnt    <= '0;
            r_res_cnt <= '0;
        end else begin
            if (w_rx_valid && r_p_st == P_OPCODE) begin
                r_acc  <= '0;
                r_bcnt <= '0;
            end else if (w_add) begin
                r_acc  <= w_acc_nx;
                r_bcnt <= r_bcnt + 1'b1;
                r_word <= {r_rx_data, r_word[23:8]};
            end
            if (w_pkt_done && r_op == 8'h10) begin
                r_res     <= w_acc_nx;
                r_res_cnt <= 3'd4;
            end else if (w_res_push) begin
                r_res     <= r_res >> 8;
                r_res_cnt <= r_res_cnt - 1'b1;
            end
        end
    end
`else
    assign w_res_push = 1'b0;
    assign w_res_byte = 8'h00;
    assign w_res_busy = 1'b0;
`endif

    assign w_push      = w_echo_push || w_res_push;
    assign w_push_data = w_res_push ? w_res_byte : r_rx_data;
    assign w_full      = r_cnt == (AW+1)'(FIFO_DEPTH);
    assign w_empty     = r_cnt == '0;
    assign w_wr        = w_push && !w_full;

    always_ff @(posedge clk_i) begin
        if (w_wr) r_mem[r_wp] <= w_push_data;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_pop);
        end
    end

    assign w_tx_end = r_tx_st == TX_BUSY && r_tx_cnt == C_LAST && r_tx_bit == 4'd9;

    // Reloading at the end of the stop bit keeps consecutive bytes gap-free.
    always_comb begin
        w_tx_nx = r_tx_st;
        w_pop   = 1'b0;
        if (r_tx_st == TX_IDLE || w_tx_end) begin
            w_pop   = !w_empty;
            w_tx_nx = w_empty ? TX_IDLE : TX_BUSY;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tx_st  <= TX_IDLE;
            r_tx_sh  <= '1;
            r_tx_cnt <= '0;
            r_tx_bit <= '0;
        end else begin
            r_tx_st <= w_tx_nx;
            if (w_pop) begin
                r_tx_sh  <= {1'b1, r_mem[r_rp], 1'b0};
                r_tx_cnt <= '0;
                r_tx_bit <= '0;
            end else if (r_tx_st == TX_BUSY) begin
                if (r_tx_cnt == C_LAST) begin
                    r_tx_cnt <= '0;
                    r_tx_bit <= r_tx_bit + 1'b1;
                    r_tx_sh  <= {1'b1, r_tx_sh[9:1]};
                end else begin
                    r_tx_cnt <= r_tx_cnt + 1'b1;
                end
            end
        end
    end

    assign tx_o   = (r_tx_st == TX_BUSY) ? r_tx_sh[0] : 1'b1;
    assign busy_o = r_p_st != P_OPCODE || r_tx_st == TX_BUSY || !w_empty || w_res_busy;
endmodule

// File: tb/tb_uart_runner.sv
// tb_uart_runner: randomized self-checking bench for uart_runner against a packet-level reference model.
module tb_uart_runner;
    localparam int CPB = 16;
`ifdef UART_RUNNER_ADD32_EN
    localparam bit ADD_EN = 1'b1;
`else
    localparam bit ADD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;
    logic tx, busy;
    int checks = 0;
    int failures = 0;
    int tx_frame_errs = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    logic [7:0] pkt[$];

    always #5 clk = ~clk;

    uart_runner #(.CLK_FREQ_HZ(1600000), .BAUD_RATE(100000), .FIFO_DEPTH(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .rx_i(rx), .tx_o(tx), .busy_o(busy)
    );

    // Serial decoder for tx_o: samples mid-bit and collects every byte the DUT sends.
    initial forever begin
        logic [7:0] b;
        @(negedge tx);
        repeat (CPB / 2) @(posedge clk);
        if (tx !== 1'b0) continue;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            b[i] = tx;
        end
        repeat (CPB) @(posedge clk);
        if (tx !== 1'b1) tx_frame_errs++;
        got.push_back(b);
    end

    // Reference: what a whole packet should produce on TX, from the packet rules alone.
    function automatic void model(input logic [7:0] p[$]);
        int len;
        logic [31:0] s;
        len = int'({p[3], p[2]});
        s = 32'd0;
        if (p[0] == 8'hEC) begin
            for (int i = 4; i < len; i++) exp_q.push_back(p[i]);
        end else if (p[0] == 8'h10 && ADD_EN) begin
            for (int i = 4; i + 3 < len; i += 4) s = s + {p[i+3], p[i+2], p[i+1], p[i]};
            for (int k = 0; k < 4; k++) exp_q.push_back(s[8*k +: 8]);
        end
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit stop = 1'b1);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic send_pkt(input logic [7:0] p[$]);
        foreach (p[i]) send_byte(p[i]);
        model(p);
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        repeat (2) @(negedge clk);
        for (int n = 0; n < 20000; n++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic start_test();
        got.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b want 1", tx); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_echo();
        bit ok;
        start_test();
        pkt = '{8'hEC, 8'hF4, 8'h0C, 8'h00, 8'h48, 8'h69, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_pkt(pkt);
        drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL echo_idle: busy_o stuck at 1 want 0"); end
        checks++;
        if (tx !== 1'b1) begin failures++; $display("FAIL echo_tx_idle: got %b want 1", tx); end
        checks++;
        if (got.size() != exp_q.size()) begin failures++; $display("FAIL echo_count: got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL echo_byte[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_add32();
        bit ok;
        start_test();
        pkt = '{8'h10, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        send_pkt(pkt);
        pkt = '{8'h10, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00};
        send_pkt(pkt);
        pkt = '{8'h10, 8'h00, 8'h04, 8'h00};
        send_pkt(pkt);
        pkt = '{8'h10, 8'h00, 8'h0B, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h09, 8'h09, 8'h09};
        send_pkt(pkt);
        drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL add32_idle: busy_o stuck at 1 want 0"); end
        checks++;
        if (got.size() != exp_q.size()) begin failures++; $display("FAIL add32_count: got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL add32_byte[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_discard();
        bit ok;
        start_test();
        pkt = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
        send_pkt(pkt);
        pkt = '{8'hEC, 8'h00, 8'h02, 8'h00};
        send_pkt(pkt);
        pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h7E};
        send_pkt(pkt);
        drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL discard_idle: busy_o stuck at 1 want 0"); end
        checks++;
        if (got.size() != exp_q.size()) begin failures++; $display("FAIL discard_count: got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL discard_byte[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_line_errors();
        bit ok;
        start_test();
        send_byte(8'hEC, 1'b0);
        repeat (3 * CPB) @(negedge clk);
        pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h33};
        send_pkt(pkt);
        repeat (2 * CPB) @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'hC3};
        send_pkt(pkt);
        drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL line_idle: busy_o stuck at 1 want 0"); end
        checks++;
        if (got.size() != exp_q.size()) begin failures++; $display("FAIL line_count: got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL line_byte[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        start_test();
        send_byte(8'hEC);
        send_byte(8'hF4);
        rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin failures++; $display("FAIL midreset_tx: got %b want 1", tx); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
        send_pkt(pkt);
        drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL midreset_idle: busy_o stuck at 1 want 0"); end
        checks++;
        if (got.size() != exp_q.size()) begin failures++; $display("FAIL midreset_count: got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL midreset_byte[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n;
        logic [7:0] op;
        start_test();
        for (int k = 0; k < 8; k++) begin
            n = int'($urandom_range(0, 9));
            case ($urandom_range(0, 2))
                0: op = 8'hEC;
                1: op = 8'h10;
                default: op = 8'($urandom_range(0, 255));
            endcase
            pkt.delete();
            pkt.push_back(op);
            pkt.push_back(8'($urandom));
            pkt.push_back(8'(n + 4));
            pkt.push_back(8'h00);
            for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
            send_pkt(pkt);
        end
        drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL b2b_idle: busy_o stuck at 1 want 0"); end
        checks++;
        if (got.size() != exp_q.size()) begin failures++; $display("FAIL b2b_count: got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL b2b_byte[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
            end
        end
        checks++;
        if (tx_frame_errs != 0) begin failures++; $display("FAIL tx_stop_bits: got %0d bad stop bits want 0", tx_frame_errs); end
    endtask

    initial begin
        test_reset();
        test_echo();
        test_add32();
        test_discard();
        test_line_errors();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
